// File: rtl/hazard_pkg.sv
// Shared types and limits for the pipeline hazard controller.
// The HAZARD_PERF_CNT_EN macro (see pipeline_hazard_ctrl) adds the performance counters.
package hazard_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LSTALL = 1'b1
  } state_t;

  localparam int LOAD_STALL_MAX = 7;
  localparam int CNT_W_DEFAULT  = 32;

endpackage

// File: rtl/load_use_compare.sv
// Pure combinational load-use detector: the decode-stage instruction reads
// a register that the execute-stage load is about to write.
module load_use_compare #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic              usesRs1,
  input  logic              usesRs2,
  input  logic [REG_AW-1:0] rd,
  input  logic              memRead,
  output logic              hz
);

  // x0 is hard-wired zero, so a load into it can never create a dependency
  assign hz = memRead && (rd != '0) &&
              ((usesRs1 && (rs1 == rd)) || (usesRs2 && (rs2 == rd)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use stall / branch flush / memory freeze controller for a 5-stage pipeline.
// Define HAZARD_PERF_CNT_EN to add the load_stall_cnt and flush_cnt counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] IF_ID_RegisterRs1,
  input  logic [REG_AW-1:0] IF_ID_RegisterRs2,
  input  logic              IF_ID_UsesRs1,
  input  logic              IF_ID_UsesRs2,
  input  logic [REG_AW-1:0] ID_EX_RegisterRd,
  input  logic              ID_EX_MemRead,
  input  logic              branch_taken,
  input  logic              mem_busy,
  output logic              stall,
  output logic              bubble,
  output logic              flush,
  output logic              freeze
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  load_stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  localparam logic [2:0] StallInit = 3'(LOAD_STALL - 1);

  logic       hz;
  state_t     stateReg, stateNext;
  logic [2:0] cntReg, cntNext;

  load_use_compare #(
    .REG_AW (REG_AW)
  ) u_cmp (
    .rs1     (IF_ID_RegisterRs1),
    .rs2     (IF_ID_RegisterRs2),
    .usesRs1 (IF_ID_UsesRs1),
    .usesRs2 (IF_ID_UsesRs2),
    .rd      (ID_EX_RegisterRd),
    .memRead (ID_EX_MemRead),
    .hz      (hz)
  );

  always_comb begin
    stall     = 1'b0;
    bubble    = 1'b0;
    flush     = 1'b0;
    freeze    = 1'b0;
    stateNext = stateReg;
    cntNext   = cntReg;
    if (rst) begin
      stateNext = IDLE;
      cntNext   = '0;
    end else if (mem_busy) begin
      freeze = 1'b1;
    end else if (branch_taken) begin
      // the stalled instruction is on the wrong path, so the flush also ends the stall
      flush     = 1'b1;
      stateNext = IDLE;
      cntNext   = '0;
    end else if (stateReg == LSTALL) begin
      stall  = 1'b1;
      bubble = 1'b1;
      if (cntReg == 3'd1) begin
        stateNext = IDLE;
        cntNext   = '0;
      end else begin
        cntNext = cntReg - 3'd1;
      end
    end else if (hz) begin
      stall  = 1'b1;
      bubble = 1'b1;
      if (LOAD_STALL > 1) begin
        stateNext = LSTALL;
        cntNext   = StallInit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg <= IDLE;
      cntReg   <= '0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] loadStallCntReg;
  logic [CNT_W-1:0] flushCntReg;

  // stall and flush are already forced low during reset and freeze, so they gate directly
  always_ff @(posedge clk) begin
    if (rst) begin
      loadStallCntReg <= '0;
      flushCntReg     <= '0;
    end else begin
      if (stall) loadStallCntReg <= loadStallCntReg + 1'b1;
      if (flush) flushCntReg     <= flushCntReg + 1'b1;
    end
  end

  assign load_stall_cnt = loadStallCntReg;
  assign flush_cnt      = flushCntReg;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: LOAD_STALL=1 and LOAD_STALL=3 instances share stimulus.
// Counter checks are active when HAZARD_PERF_CNT_EN is defined.
module tb_pipeline_hazard_ctrl;

  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic [AW-1:0] rs1, rs2, rd;
  logic          uses1, uses2, memRead, branchTaken, memBusy;
  logic [1:0]    stallV, bubbleV, flushV, freezeV;
  logic [CW-1:0] lscV [2];
  logic [CW-1:0] fcV  [2];

  int compared   = 0;
  int mismatched = 0;
  int txn        = 0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    pipeline_hazard_ctrl #(
      .REG_AW     (AW),
      .LOAD_STALL ((gi == 0) ? 1 : 3),
      .CNT_W      (CW)
    ) dut (
      .clk               (clk),
      .rst               (rst),
      .IF_ID_RegisterRs1 (rs1),
      .IF_ID_RegisterRs2 (rs2),
      .IF_ID_UsesRs1     (uses1),
      .IF_ID_UsesRs2     (uses2),
      .ID_EX_RegisterRd  (rd),
      .ID_EX_MemRead     (memRead),
      .branch_taken      (branchTaken),
      .mem_busy          (memBusy),
      .stall             (stallV[gi]),
      .bubble            (bubbleV[gi]),
      .flush             (flushV[gi]),
      .freeze            (freezeV[gi])
`ifdef HAZARD_PERF_CNT_EN
      ,
      .load_stall_cnt    (lscV[gi]),
      .flush_cnt         (fcV[gi])
`endif
    );
`ifndef HAZARD_PERF_CNT_EN
    assign lscV[gi] = '0;
    assign fcV[gi]  = '0;
`endif
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s inst%0d t=%0t actual=%0h required=%0h", nm, inst, $time, act, exp);
    end
  endtask

  // Behavioural model: remaining stall cycles per load-use event, plus event counts.
  int rem  [2] = '{0, 0};
  int lscM [2] = '{0, 0};
  int fcM  [2] = '{0, 0};

  always @(negedge clk) begin
    bit hzM, eS, eF, eZ;
    int lim;
    hzM = memRead && (rd != 0) && ((uses1 && rs1 == rd) || (uses2 && rs2 == rd));
    for (int k = 0; k < 2; k++) begin
      lim = (k == 0) ? 1 : 3;
`ifdef HAZARD_PERF_CNT_EN
      chk("load_stall_cnt", k, 32'(lscV[k]), 32'(lscM[k] % (1 << CW)));
      chk("flush_cnt", k, 32'(fcV[k]), 32'(fcM[k] % (1 << CW)));
`endif
      eS = 0; eF = 0; eZ = 0;
      if (rst) rem[k] = 0;
      else if (memBusy) eZ = 1;
      else if (branchTaken) begin eF = 1; rem[k] = 0; end
      else if (rem[k] > 0) begin eS = 1; rem[k]--; end
      else if (hzM) begin eS = 1; rem[k] = lim - 1; end
      chk("model_stall", k, 32'(stallV[k]), 32'(eS));
      chk("model_bubble", k, 32'(bubbleV[k]), 32'(eS));
      chk("model_flush", k, 32'(flushV[k]), 32'(eF));
      chk("model_freeze", k, 32'(freezeV[k]), 32'(eZ));
      if (rst) begin
        lscM[k] = 0;
        fcM[k]  = 0;
      end else begin
        lscM[k] += int'(eS);
        fcM[k]  += int'(eF);
      end
    end
  end

  // One transaction = one cycle of inputs; returns mid-cycle so literal checks see settled outputs.
  task automatic drive(input bit r, input bit mb, input bit br, input bit mr, input int d,
                       input int s1, input bit u1, input int s2, input bit u2);
    @(posedge clk);
    #1;
    rst = r; memBusy = mb; branchTaken = br; memRead = mr;
    rd = AW'(d); rs1 = AW'(s1); uses1 = u1; rs2 = AW'(s2); uses2 = u2;
    txn++;
    #2;
    $display("txn %0d rst=%0b mb=%0b br=%0b mr=%0b rd=%0d rs1=%0d/%0b rs2=%0d/%0b -> stall=%b flush=%b freeze=%b",
             txn, r, mb, br, mr, d, s1, u1, s2, u2, stallV, flushV, freezeV);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; memBusy = 1'b0; branchTaken = 1'b0; memRead = 1'b0;
    rd = '0; rs1 = '0; rs2 = '0; uses1 = 1'b0; uses2 = 1'b0;

    // reset dominates everything, even a hazard with mem_busy and branch
    drive(1, 1, 1, 1, 5, 5, 1, 0, 0);
    chk("rst_outputs", 0, 32'({stallV, bubbleV, flushV, freezeV}), 32'h0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // load-use on rs1; freeze in the middle of the 3-cycle stall
    drive(0, 0, 0, 1, 5, 5, 1, 0, 0);
    chk("lu_stall", 0, 32'(stallV[0]), 32'd1);
    chk("lu_bubble", 0, 32'(bubbleV[0]), 32'd1);
    chk("lu_stall", 1, 32'(stallV[1]), 32'd1);
    idle();
    chk("lu_after", 0, 32'(stallV[0]), 32'd0);
    chk("lu_cycle2", 1, 32'(stallV[1]), 32'd1);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("frozen_freeze", 1, 32'(freezeV[1]), 32'd1);
    chk("frozen_stall", 1, 32'(stallV[1]), 32'd0);
    idle();
    chk("lu_cycle3", 1, 32'(stallV[1]), 32'd1);
    idle();
    chk("lu_done", 1, 32'(stallV[1]), 32'd0);

    // no stall for rd==0 or an unused source operand
    drive(0, 0, 0, 1, 0, 0, 0, 0, 1);
    chk("rd_zero", 1, 32'(stallV), 32'd0);
    drive(0, 0, 0, 1, 7, 0, 0, 7, 0);
    chk("rs2_unused", 1, 32'(stallV), 32'd0);

    // branch beats hazard
    drive(0, 0, 1, 1, 5, 5, 1, 0, 0);
    chk("br_flush", 0, 32'(flushV), 32'h3);
    chk("br_stall", 0, 32'(stallV), 32'h0);
    idle();
    chk("br_next_idle", 1, 32'(stallV[1]), 32'd0);

    // reset in the second stall cycle aborts the stall
    drive(0, 0, 0, 1, 5, 0, 0, 5, 1);
    drive(1, 0, 0, 1, 5, 0, 0, 5, 1);
    chk("rst_lstall", 1, 32'({stallV[1], bubbleV[1], flushV[1], freezeV[1]}), 32'h0);
    idle();
    chk("rst_abort", 1, 32'(stallV[1]), 32'd0);

    // counter wrap: 17 stall cycles, then 2 flushes
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) drive(0, 0, 0, 1, 3, 3, 1, 0, 0);
    idle();
`ifdef HAZARD_PERF_CNT_EN
    chk("lsc_wrap", 0, 32'(lscV[0]), 32'd1);
`endif
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
    idle();
`ifdef HAZARD_PERF_CNT_EN
    chk("flush_cnt2", 0, 32'(fcV[0]), 32'd2);
    chk("flush_cnt2", 1, 32'(fcV[1]), 32'd2);
`endif

    // mixed traffic checked by the model only
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 40) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 1) == 1);
    end
    idle();
    idle();
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
